wb_arbiter: RTL and testbench

//  Writeback arbiter. It merges results from NUM_SRC producers (ALU, LSU, MDU) into the single

---
 rtl/wb_arbiter_pkg.sv | 30 +++
 rtl/wb_arbiter_if.sv | 32 +++
 rtl/wb_prio_pick.sv | 18 +
 rtl/wb_arbiter.sv | 116 +++++++++++
 tb/tb_wb_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// ============================================================================
// Module : wb_arbiter_pkg
// Brief  : Shared constants and helpers for the writeback arbiter.
//          XLEN macro (if defined) overrides the default datapath width.
// Rev    : 1.0
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

package wb_arbiter_pkg;

    localparam int WB_XLEN = `XLEN;

    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_LSU = 1;
    localparam int WB_SRC_MDU = 2;
    localparam int WB_NUM_SRC = 3;
    localparam int REG_ADDR_W = 5;

    // Wide enough to hold the saturation value itself.
    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_arbiter_if.sv
// ============================================================================
// Module : wb_arbiter_if
// Brief  : Producer handshake and register-file write port of the arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface wb_arbiter_if #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 3
);
    logic [NUM_SRC-1:0]      src_valid;
    logic [NUM_SRC-1:0]      src_ready;
    logic [NUM_SRC*5-1:0]    src_rd_addr;
    logic [NUM_SRC*XLEN-1:0] src_rd_data;
    logic [4:0]              rd_addr;
    logic [XLEN-1:0]         rd_data;
    logic                    rd_wen;
    logic                    wb_busy;

    modport slave (
        input  src_valid, src_rd_addr, src_rd_data,
        output src_ready, rd_addr, rd_data, rd_wen, wb_busy
    );

    modport master (
        output src_valid, src_rd_addr, src_rd_data,
        input  src_ready, rd_addr, rd_data, rd_wen, wb_busy
    );
endinterface

`default_nettype wire

// File: rtl/wb_prio_pick.sv
// ============================================================================
// Module : wb_prio_pick
// Brief  : Combinational find-first-set; one-hot grant of the lowest request.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wb_prio_pick #(
    parameter int N = 3
) (
    input  wire logic [N-1:0] req,
    output logic      [N-1:0] gnt
);
    // Two's-complement trick isolates the least significant set bit.
    assign gnt = req & (~req + N'(1));
endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module : wb_arbiter
// Brief  : Fixed-priority writeback arbiter with starvation counters and a
//          registered regfile write port. WB_PERF_CNT_EN adds perf counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN         = WB_XLEN,
    parameter int NUM_SRC      = WB_NUM_SRC,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic        clk,
    input  wire logic        reset,
    wb_arbiter_if.slave      bus
`ifdef WB_PERF_CNT_EN
    ,
    output logic [63:0]      perf_wb_commits,
    output logic [63:0]      perf_wb_stalls
`endif
);
    localparam int CW = cnt_width(STARVE_LIMIT);

    logic [CW-1:0]         wait_cnt [NUM_SRC];
    logic [NUM_SRC-1:0]    urgent_req;
    logic [NUM_SRC-1:0]    urgent_gnt;
    logic [NUM_SRC-1:0]    plain_gnt;
    logic [NUM_SRC-1:0]    grant;
    logic [4:0]            sel_addr;
    logic [XLEN-1:0]       sel_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign urgent_req[gi] = bus.src_valid[gi] &&
                                    (wait_cnt[gi] >= CW'(STARVE_LIMIT));

            always_ff @(posedge clk) begin
                if (reset || !bus.src_valid[gi] || grant[gi]) begin
                    wait_cnt[gi] <= '0;
                end else if (wait_cnt[gi] != CW'(STARVE_LIMIT)) begin
                    wait_cnt[gi] <= wait_cnt[gi] + CW'(1);
                end
            end
        end
    endgenerate

    wb_prio_pick #(.N(NUM_SRC)) u_pick_urgent (
        .req (urgent_req),
        .gnt (urgent_gnt)
    );

    wb_prio_pick #(.N(NUM_SRC)) u_pick_plain (
        .req (bus.src_valid),
        .gnt (plain_gnt)
    );

    always_comb begin
        grant = '0;
        if (!reset) begin
            grant = (|urgent_gnt) ? urgent_gnt : plain_gnt;
        end
    end

    assign bus.src_ready = grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                sel_addr = bus.src_rd_addr[5*i +: 5];
                sel_data = bus.src_rd_data[XLEN*i +: XLEN];
            end
        end
    end

    // x0 writes still complete the handshake but never reach the regfile.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rd_wen  <= 1'b0;
            bus.rd_addr <= '0;
            bus.rd_data <= '0;
        end else begin
            bus.rd_wen <= (|grant) && (sel_addr != 5'd0);
            if (|grant) begin
                bus.rd_addr <= sel_addr;
                bus.rd_data <= sel_data;
            end
        end
    end

    assign bus.wb_busy = (|bus.src_valid) | bus.rd_wen;

`ifdef WB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_wb_commits <= '0;
            perf_wb_stalls  <= '0;
        end else begin
            if (bus.rd_wen) begin
                perf_wb_commits <= perf_wb_commits + 64'd1;
            end
            if (|(bus.src_valid & ~grant)) begin
                perf_wb_stalls <= perf_wb_stalls + 64'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module : tb_wb_arbiter
// Brief  : Directed bench with a cycle-level reference model for wb_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_wb_arbiter;
    localparam int XLEN    = 32;
    localparam int NUM_SRC = 3;
    localparam int LIMIT   = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(.XLEN(XLEN), .NUM_SRC(NUM_SRC)) bus ();

`ifdef WB_PERF_CNT_EN
    logic [63:0] perf_wb_commits;
    logic [63:0] perf_wb_stalls;
`endif

    wb_arbiter #(
        .XLEN         (XLEN),
        .NUM_SRC      (NUM_SRC),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef WB_PERF_CNT_EN
        ,
        .perf_wb_commits (perf_wb_commits),
        .perf_wb_stalls  (perf_wb_stalls)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: age = consecutive cycles a source has waited while valid.
    int                 age [NUM_SRC];
    logic               exp_wen  = 1'b0;
    logic [4:0]         exp_addr = '0;
    logic [XLEN-1:0]    exp_data = '0;
    longint unsigned    m_commits = 0;
    longint unsigned    m_stalls  = 0;
    bit                 primed    = 1'b0;

    always @(negedge clk) begin
        int g;
        int nvalid;
        if (primed) begin
            check("rd_wen",  64'(bus.rd_wen),  64'(exp_wen));
            check("rd_addr", 64'(bus.rd_addr), 64'(exp_addr));
            check("rd_data", 64'(bus.rd_data), 64'(exp_data));
            check("wb_busy", 64'(bus.wb_busy), 64'((|bus.src_valid) | exp_wen));
`ifdef WB_PERF_CNT_EN
            check("perf_commits", perf_wb_commits, m_commits);
            check("perf_stalls",  perf_wb_stalls,  m_stalls);
`endif
        end
        if (reset) begin
            check("src_ready_in_reset", 64'(bus.src_ready), 64'd0);
            for (int i = 0; i < NUM_SRC; i++) age[i] = 0;
            exp_wen   = 1'b0;
            exp_addr  = '0;
            exp_data  = '0;
            m_commits = 0;
            m_stalls  = 0;
            primed    = 1'b1;
        end else if (primed) begin
            g = -1;
            for (int i = 0; i < NUM_SRC; i++)
                if (g < 0 && bus.src_valid[i] && age[i] >= LIMIT) g = i;
            for (int i = 0; i < NUM_SRC; i++)
                if (g < 0 && bus.src_valid[i]) g = i;
            check("src_ready", 64'(bus.src_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
            nvalid = 0;
            for (int i = 0; i < NUM_SRC; i++) nvalid += int'(bus.src_valid[i]);
            if (exp_wen) m_commits++;
            if (nvalid > ((g >= 0) ? 1 : 0)) m_stalls++;
            for (int i = 0; i < NUM_SRC; i++)
                age[i] = (bus.src_valid[i] && i != g) ? age[i] + 1 : 0;
            if (g >= 0) begin
                exp_addr = bus.src_rd_addr[5*g +: 5];
                exp_data = bus.src_rd_data[XLEN*g +: XLEN];
                exp_wen  = (exp_addr != 5'd0);
            end else begin
                exp_wen = 1'b0;
            end
        end
    end

    task automatic set_src(input int i, input bit v, input logic [4:0] a, input logic [XLEN-1:0] d);
        bus.src_valid[i]             = v;
        bus.src_rd_addr[5*i +: 5]    = a;
        bus.src_rd_data[XLEN*i +: XLEN] = d;
    endtask

    task automatic idle();
        for (int i = 0; i < NUM_SRC; i++) set_src(i, 1'b0, 5'd0, '0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic all_valid();
        set_src(0, 1'b1, 5'd1, 32'hA0A0_0001);
        set_src(1, 1'b1, 5'd2, 32'hB0B0_0002);
        set_src(2, 1'b1, 5'd3, 32'hC0C0_0003);
    endtask

    logic [2:0] t2_ready [7] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b001};
    logic [2:0] t4_ready [5] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100};

    initial begin
        bus.src_valid   = '0;
        bus.src_rd_addr = '0;
        bus.src_rd_data = '0;
        reset = 1'b1;
        repeat (2) next_cycle();
        reset = 1'b0;
        #2;
        check("reset_rd_wen",  64'(bus.rd_wen),  64'd0);
        check("reset_rd_addr", 64'(bus.rd_addr), 64'd0);
        check("reset_rd_data", 64'(bus.rd_data), 64'd0);
        next_cycle();

        // Single LSU result
        set_src(1, 1'b1, 5'd5, 32'hDEADBEEF);
        #2 check("t1_ready", 64'(bus.src_ready), 64'b010);
        next_cycle();
        idle();
        #2;
        check("t1_wen",  64'(bus.rd_wen),  64'd1);
        check("t1_addr", 64'(bus.rd_addr), 64'd5);
        check("t1_data", 64'(bus.rd_data), 64'hDEADBEEF);
        next_cycle();
        #2 check("t1_wen_off", 64'(bus.rd_wen), 64'd0);
        next_cycle();

        // Three contending sources held valid
        for (int c = 0; c < 7; c++) begin
            all_valid();
            #2;
            check("t2_ready", 64'(bus.src_ready), 64'(t2_ready[c]));
            if (c >= 1) check("t2_wen", 64'(bus.rd_wen), 64'd1);
            next_cycle();
        end
        idle();
        #2;
        check("t2_wen_tail",  64'(bus.rd_wen),  64'd1);
        check("t2_addr_tail", 64'(bus.rd_addr), 64'd1);
        next_cycle();

        // Write to x0
        set_src(0, 1'b1, 5'd0, 32'h0000_1234);
        #2 check("t3_ready", 64'(bus.src_ready), 64'b001);
        next_cycle();
        idle();
        #2 check("t3_wen", 64'(bus.rd_wen), 64'd0);
        next_cycle();

        // MDU waits, drops valid, re-presents
        for (int c = 0; c < 3; c++) begin
            set_src(0, 1'b1, 5'd8, 32'h0000_0100 + c);
            set_src(2, 1'b1, 5'd9, 32'h0000_0999);
            #2 check("t4_wait", 64'(bus.src_ready), 64'b001);
            next_cycle();
        end
        set_src(0, 1'b1, 5'd8, 32'h0000_0200);
        set_src(2, 1'b0, 5'd9, 32'h0000_0999);
        #2 check("t4_drop", 64'(bus.src_ready), 64'b001);
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            set_src(0, 1'b1, 5'd8, 32'h0000_0300 + c);
            set_src(2, 1'b1, 5'd10, 32'h0000_0AAA);
            #2 check("t4_ready", 64'(bus.src_ready), 64'(t4_ready[c]));
            next_cycle();
        end
        idle();
        #2;
        check("t4_addr", 64'(bus.rd_addr), 64'd10);
        check("t4_data", 64'(bus.rd_data), 64'h0AAA);
        next_cycle();

        // Reset while a write is in flight
        all_valid();
        #2 check("t5_pre", 64'(bus.src_ready), 64'b001);
        next_cycle();
        reset = 1'b1;
        #2;
        check("t5_wen_inflight", 64'(bus.rd_wen),    64'd1);
        check("t5_ready_rst",    64'(bus.src_ready), 64'd0);
        next_cycle();
        reset = 1'b0;
        #2;
        check("t5_wen_post",   64'(bus.rd_wen),    64'd0);
        check("t5_ready_post", 64'(bus.src_ready), 64'b001);
        next_cycle();
        idle();
        repeat (2) next_cycle();

`ifdef WB_PERF_CNT_EN
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            set_src(0, 1'b1, 5'd7, 32'h0000_7000 + c);
            if (c >= 7) set_src(1, 1'b1, 5'd12, 32'h0000_0C0C);
            next_cycle();
        end
        idle();
        next_cycle();
        #2;
        check("t6_commits", perf_wb_commits, 64'd10);
        check("t6_stalls",  perf_wb_stalls,  64'd3);
        next_cycle();
`endif

        repeat (2) next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
